// File: rtl/mips32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips32_pkg
// Description : Shared opcodes, ALU function codes, FSM states and
//               instruction field positions for the multi-cycle MIPS32 core.
// Revision    : 1.0 - initial release
// ============================================================================
package mips32_pkg;

    // Opcodes outside the ALU group
    localparam logic [5:0] OP_LD   = 6'b110000;
    localparam logic [5:0] OP_ST   = 6'b110001;
    localparam logic [5:0] OP_BEQZ = 6'b110100;
    localparam logic [5:0] OP_BNEZ = 6'b110101;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // ALU function codes carried in op[3:0] when op[5] is clear
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MUL  = 4'd2;
    localparam logic [3:0] ALU_SGTU = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;

    // Instruction sequencing states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6
    } state_e;

    // Instruction field slice positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS1_MSB = 20;
    localparam int RS1_LSB = 16;
    localparam int RS2_MSB = 15;
    localparam int RS2_LSB = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/mips32_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mips32_regfile
// Description : 32 x XLEN register file, three operand read ports, one debug
//               read port, one write port. r0 is hard-wired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mips32_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    input  logic [4:0]      ra3_i,
    input  logic [4:0]      dbg_raddr_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    output logic [XLEN-1:0] rd3_o,
    output logic [XLEN-1:0] dbg_rdata_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [32];

    // Clear on reset; writes to r0 are dropped so it always reads zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o       = regs_q[ra1_i];
    assign rd2_o       = regs_q[ra2_i];
    assign rd3_o       = regs_q[ra3_i];
    assign dbg_rdata_o = regs_q[dbg_raddr_i];

endmodule
`default_nettype wire

// File: rtl/mips32_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : mips32_multicycle
// Description : Multi-cycle MIPS32-style core (IF/ID/EX/MEM/WB sequencing)
//               with internal instruction/data memories, program-load port,
//               start/halt handshake, retired counter and debug reg port.
//               Optional macro MIPS32_MC_TRAP_EN: undefined opcodes halt the
//               core and raise trap instead of executing as NOPs.
// Revision    : 1.0 - initial release
// ============================================================================
module mips32_multicycle
    import mips32_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    input  logic                          start,
    output logic                          busy,
    output logic                          halted,
    output logic                          trap,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic [31:0]                   instret,
    input  logic [4:0]                    dbg_raddr,
    output logic [XLEN-1:0]               dbg_rdata
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];

    state_e          state_q, state_d;
    logic [IAW-1:0]  pc_q, pc_d;
    logic [31:0]     instret_q, instret_d, ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, d_q, d_d, imm_q, imm_d, res_q, res_d;
    logic [XLEN-1:0] rd1, rd2, rd3, op2, alu_res;

    logic [5:0] op;
    logic [3:0] func;
    logic       is_alu, is_ld, is_st, is_br, is_halt, illegal;
    logic       start_ok, retire, br_taken, rf_we, dmem_we;

    assign op       = ir_q[OP_MSB:OP_LSB];
    assign func     = op[3:0];
    assign is_alu   = ~op[5] && (func <= ALU_AND);
    assign is_ld    = (op == OP_LD);
    assign is_st    = (op == OP_ST);
    assign is_br    = (op == OP_BEQZ) || (op == OP_BNEZ);
    assign is_halt  = (op == OP_HALT);
    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_HALT));
    // BEQZ takes on A==0, BNEZ (op[0]=1) on A!=0
    assign br_taken = is_br && ((a_q == '0) ^ op[0]);

`ifdef MIPS32_MC_TRAP_EN
    logic trap_q;
    assign illegal = ~(is_alu | is_ld | is_st | is_br | is_halt);
    // Sticky illegal-opcode flag, cleared when execution is restarted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                trap_q <= 1'b0;
        else if (start_ok)                       trap_q <= 1'b0;
        else if ((state_q == ST_ID) && illegal)  trap_q <= 1'b1;
    end
    assign trap = trap_q;
`else
    assign illegal = 1'b0;
    assign trap    = 1'b0;
`endif

    mips32_regfile #(.XLEN(XLEN)) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .ra1_i       (ir_q[RS1_MSB:RS1_LSB]),
        .ra2_i       (ir_q[RS2_MSB:RS2_LSB]),
        .ra3_i       (ir_q[RD_MSB:RD_LSB]),
        .dbg_raddr_i (dbg_raddr),
        .rd1_o       (rd1),
        .rd2_o       (rd2),
        .rd3_o       (rd3),
        .dbg_rdata_o (dbg_rdata),
        .we_i        (rf_we),
        .wa_i        (ir_q[RD_MSB:RD_LSB]),
        .wd_i        (res_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: if (start) state_d = ST_IF;
            ST_IF:            state_d = ST_ID;
            ST_ID:            state_d = (is_halt || illegal) ? ST_HALT : ST_EX;
            ST_EX: begin
                if (is_alu)              state_d = ST_WB;
                else if (is_ld || is_st) state_d = ST_MEM;
                else                     state_d = ST_IF;
            end
            ST_MEM:           state_d = is_ld ? ST_WB : ST_IF;
            ST_WB:            state_d = ST_IF;
            default:          state_d = ST_IDLE;
        endcase
    end

    // State-decoded status and control strobes
    always_comb begin
        busy    = (state_q == ST_IF) || (state_q == ST_ID) || (state_q == ST_EX) ||
                  (state_q == ST_MEM) || (state_q == ST_WB);
        halted  = (state_q == ST_HALT);
        retire  = ((state_q == ST_EX) && !is_alu && !is_ld && !is_st) ||
                  ((state_q == ST_MEM) && is_st) || (state_q == ST_WB);
        rf_we   = (state_q == ST_WB);
        dmem_we = (state_q == ST_MEM) && is_st;
    end

    // ALU; second operand is the immediate when op[4] is set
    always_comb begin
        op2 = op[4] ? imm_q : b_q;
        case (func)
            ALU_ADD:  alu_res = a_q + op2;
            ALU_SUB:  alu_res = a_q - op2;
            ALU_MUL:  alu_res = a_q * op2;
            ALU_SGTU: alu_res = {{(XLEN-1){1'b0}}, (a_q > op2)};
            ALU_OR:   alu_res = a_q | op2;
            ALU_AND:  alu_res = a_q & op2;
            default:  alu_res = '0;
        endcase
    end

    // Datapath next values: fetch, operand latch, execute/memory result, retire
    always_comb begin
        pc_d      = pc_q;
        instret_d = instret_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        d_d       = d_q;
        imm_d     = imm_q;
        res_d     = res_q;
        if (start_ok)           pc_d = '0;
        if (state_q == ST_IF)   ir_d = imem[pc_q];
        if (state_q == ST_ID) begin
            a_d   = rd1;
            b_d   = rd2 << ir_q[SH_MSB:SH_LSB];
            d_d   = rd3;
            imm_d = {{(XLEN-16){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:IMM_LSB]};
        end
        if (state_q == ST_EX)             res_d = (is_ld || is_st) ? (a_q + imm_q) : alu_res;
        if ((state_q == ST_MEM) && is_ld) res_d = dmem[res_q[DAW-1:0]];
        if (retire) begin
            pc_d      = br_taken ? (pc_q + IAW'(1) + imm_q[IAW-1:0]) : (pc_q + IAW'(1));
            instret_d = (instret_q == '1) ? instret_q : (instret_q + 32'd1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= '0;
            instret_q <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            d_q       <= '0;
            imm_q     <= '0;
            res_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            instret_q <= instret_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            d_q       <= d_d;
            imm_q     <= imm_d;
            res_q     <= res_d;
        end
    end

    // Program load, accepted only while the core is not executing
    always_ff @(posedge clk) begin
        if (prog_we && ((state_q == ST_IDLE) || (state_q == ST_HALT))) imem[prog_addr] <= prog_data;
    end

    // Store commits on the MEM edge only
    always_ff @(posedge clk) begin
        if (dmem_we) dmem[res_q[DAW-1:0]] <= d_q;
    end

    assign pc      = pc_q;
    assign instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mips32_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips32_multicycle
// Description : Self-checking bench for mips32_multicycle: directed programs
//               plus random straight-line programs against an ISA-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips32_multicycle;

    localparam int XLEN = 32, IMEM_DEPTH = 64, DMEM_DEPTH = 16;
    localparam logic [5:0] L_ADD = 6'h00, L_ADDI = 6'h10, L_SUBI = 6'h11;
    localparam logic [5:0] L_LD = 6'h30, L_ST = 6'h31, L_BEQZ = 6'h34, L_BNEZ = 6'h35;
    localparam logic [31:0] HALTW = 32'hFC00_0000;

    logic        clk = 1'b0, rst = 1'b0, prog_we = 1'b0, start = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic [4:0]  dbg_raddr = '0;
    wire         busy, halted, trap;
    wire  [5:0]  pc;
    wire  [31:0] instret, dbg_rdata;

    int total = 0, bad = 0;
    logic [31:0] prog [$];

    // ISA-level reference state
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [DMEM_DEPTH];
    bit          m_dval [DMEM_DEPTH];
    int          m_cyc, m_ret;

    mips32_multicycle #(.XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .busy(busy), .halted(halted), .trap(trap), .pc(pc), .instret(instret),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] sh);
        return {op, rd, rs1, rs2, sh, 6'd0};
    endfunction

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic load_prog();
        foreach (prog[i]) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = 6'(i); prog_data = prog[i];
        end
        @(negedge clk) prog_we = 1'b0;
    endtask

    // Pulse start, then count cycles until halted (bounded)
    task automatic run_prog(output int cyc);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (!halted && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic rdreg(input logic [4:0] idx, output logic [31:0] v);
        dbg_raddr = idx; #1; v = dbg_rdata;
    endtask

    // Architectural effect of one non-HALT instruction on the model
    task automatic m_exec(input logic [31:0] ins);
        logic [5:0] op; logic [4:0] rd, rs1, rs2, sh;
        logic [31:0] a, b, d, imm, op2, y, ea;
        int idx;
        op = ins[31:26]; rd = ins[25:21]; rs1 = ins[20:16]; rs2 = ins[15:11]; sh = ins[10:6];
        imm = {{16{ins[15]}}, ins[15:0]};
        a = m_regs[rs1]; b = m_regs[rs2] << sh; d = m_regs[rd];
        ea = a + imm; idx = int'(ea % 32'(DMEM_DEPTH));
        m_ret++;
        if (op[5] == 1'b0 && op[3:0] < 4'd6) begin
            op2 = op[4] ? imm : b;
            case (op[3:0])
                4'd0: y = a + op2;
                4'd1: y = a - op2;
                4'd2: y = a * op2;
                4'd3: y = (a > op2) ? 32'd1 : 32'd0;
                4'd4: y = a | op2;
                default: y = a & op2;
            endcase
            if (rd != 5'd0) m_regs[rd] = y;
            m_cyc += 4;
        end else if (op == L_LD) begin
            if (rd != 5'd0) m_regs[rd] = m_dmem[idx];
            m_cyc += 5;
        end else if (op == L_ST) begin
            m_dmem[idx] = d; m_dval[idx] = 1'b1;
            m_cyc += 4;
        end else begin
            m_cyc += 3;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (halted !== 1'b0)  begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        total++; if (trap !== 1'b0)    begin bad++; $display("FAIL reset_trap: got %b want 0", trap); end
        total++; if (pc !== 6'd0)      begin bad++; $display("FAIL reset_pc: got %0d want 0", pc); end
        total++; if (instret !== 32'd0) begin bad++; $display("FAIL reset_instret: got %0d want 0", instret); end
        @(negedge clk) rst = 1'b1;
        rdreg(5'd7, v);
        total++; if (v !== 32'd0)      begin bad++; $display("FAIL reset_r7: got %0h want 0", v); end
    endtask

    task automatic test_arith();
        int cyc; logic [31:0] v;
        do_reset(); prog.delete();
        prog.push_back(enc_i(L_ADDI, 5'd1, 5'd0, 16'd5));
        prog.push_back(enc_i(L_ADDI, 5'd2, 5'd0, 16'd7));
        prog.push_back(enc_r(L_ADD, 5'd3, 5'd1, 5'd2, 5'd0));
        prog.push_back(HALTW);
        load_prog(); run_prog(cyc); rdreg(5'd3, v);
        total++; if (halted !== 1'b1)   begin bad++; $display("FAIL arith_halted: got %b want 1", halted); end
        total++; if (v !== 32'd12)      begin bad++; $display("FAIL arith_r3: got %0d want 12", v); end
        total++; if (instret !== 32'd3) begin bad++; $display("FAIL arith_instret: got %0d want 3", instret); end
        total++; if (pc !== 6'd3)       begin bad++; $display("FAIL arith_pc: got %0d want 3", pc); end
        total++; if (cyc !== 14)        begin bad++; $display("FAIL arith_cycles: got %0d want 14", cyc); end
    endtask

    task automatic test_ldst();
        int cyc; logic [31:0] v;
        do_reset(); prog.delete();
        prog.push_back(enc_i(L_ADDI, 5'd1, 5'd0, 16'd9));
        prog.push_back(enc_i(L_ST, 5'd1, 5'd0, 16'd4));
        prog.push_back(enc_i(L_LD, 5'd2, 5'd0, 16'd4));
        prog.push_back(HALTW);
        load_prog(); run_prog(cyc); rdreg(5'd2, v);
        total++; if (v !== 32'd9)  begin bad++; $display("FAIL ldst_r2: got %0d want 9", v); end
        total++; if (cyc !== 15)   begin bad++; $display("FAIL ldst_cycles: got %0d want 15", cyc); end
    endtask

    task automatic test_countdown();
        int cyc; logic [31:0] v;
        do_reset(); prog.delete();
        prog.push_back(enc_i(L_ADDI, 5'd1, 5'd0, 16'd3));
        prog.push_back(enc_i(L_SUBI, 5'd1, 5'd1, 16'd1));
        prog.push_back(enc_i(L_BNEZ, 5'd0, 5'd1, 16'hFFFE));
        prog.push_back(HALTW);
        load_prog(); run_prog(cyc); rdreg(5'd1, v);
        total++; if (v !== 32'd0)       begin bad++; $display("FAIL countdown_r1: got %0d want 0", v); end
        total++; if (instret !== 32'd7) begin bad++; $display("FAIL countdown_instret: got %0d want 7", instret); end
        total++; if (pc !== 6'd3)       begin bad++; $display("FAIL countdown_pc: got %0d want 3", pc); end
    endtask

    task automatic test_r0_and_guard();
        int cyc; logic [31:0] v;
        do_reset(); prog.delete();
        prog.push_back(enc_i(L_ADDI, 5'd1, 5'd0, 16'd5));
        prog.push_back(enc_i(L_ADDI, 5'd0, 5'd0, 16'd5));
        prog.push_back(enc_i(L_ADDI, 5'd2, 5'd0, 16'd6));
        prog.push_back(HALTW);
        load_prog();
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL guard_busy: got %b want 1", busy); end
        // Overwrite a not-yet-fetched word and re-pulse start; both must be ignored
        @(negedge clk); prog_we = 1'b1; prog_addr = 6'd2; prog_data = HALTW; start = 1'b1;
        @(negedge clk); prog_we = 1'b0; start = 1'b0;
        cyc = 0;
        while (!halted && cyc < 200) begin @(posedge clk); #1; cyc++; end
        total++; if (halted !== 1'b1)   begin bad++; $display("FAIL guard_halted: got %b want 1", halted); end
        total++; if (pc !== 6'd3)       begin bad++; $display("FAIL guard_pc: got %0d want 3", pc); end
        total++; if (instret !== 32'd3) begin bad++; $display("FAIL guard_instret: got %0d want 3", instret); end
        rdreg(5'd2, v);
        total++; if (v !== 32'd6)       begin bad++; $display("FAIL guard_r2: got %0d want 6", v); end
        rdreg(5'd0, v);
        total++; if (v !== 32'd0)       begin bad++; $display("FAIL r0_zero: got %0d want 0", v); end
    endtask

    task automatic test_branch_wrap();
        int cyc;
        do_reset(); prog.delete();
        prog.push_back(enc_i(L_BEQZ, 5'd0, 5'd0, 16'hFFFE));
        load_prog();
        @(negedge clk); prog_we = 1'b1; prog_addr = 6'd63; prog_data = HALTW;
        @(negedge clk) prog_we = 1'b0;
        run_prog(cyc);
        total++; if (pc !== 6'd63)      begin bad++; $display("FAIL wrap_pc: got %0d want 63", pc); end
        total++; if (instret !== 32'd1) begin bad++; $display("FAIL wrap_instret: got %0d want 1", instret); end
        total++; if (cyc !== 5)         begin bad++; $display("FAIL wrap_cycles: got %0d want 5", cyc); end
    endtask

    task automatic test_reset_mid_store();
        int cyc; logic [31:0] v;
        do_reset(); prog.delete();
        prog.push_back(enc_i(L_ADDI, 5'd1, 5'd0, 16'd9));
        prog.push_back(enc_i(L_ST, 5'd1, 5'd0, 16'd2));
        prog.push_back(HALTW);
        load_prog(); run_prog(cyc);
        do_reset(); prog.delete();
        prog.push_back(enc_i(L_ADDI, 5'd1, 5'd0, 16'd77));
        prog.push_back(enc_i(L_ST, 5'd1, 5'd0, 16'd2));
        prog.push_back(HALTW);
        load_prog();
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (halted !== 1'b0)   begin bad++; $display("FAIL abort_halted: got %b want 0", halted); end
        total++; if (pc !== 6'd0)       begin bad++; $display("FAIL abort_pc: got %0d want 0", pc); end
        total++; if (instret !== 32'd0) begin bad++; $display("FAIL abort_instret: got %0d want 0", instret); end
        rdreg(5'd1, v);
        total++; if (v !== 32'd0)       begin bad++; $display("FAIL abort_r1: got %0d want 0", v); end
        @(negedge clk) rst = 1'b1;
        prog.delete();
        prog.push_back(enc_i(L_LD, 5'd2, 5'd0, 16'd2));
        prog.push_back(HALTW);
        load_prog(); run_prog(cyc); rdreg(5'd2, v);
        total++; if (v !== 32'd9)       begin bad++; $display("FAIL abort_dmem2: got %0d want 9", v); end
        total++; if (instret !== 32'd1) begin bad++; $display("FAIL abort_rerun_instret: got %0d want 1", instret); end
    endtask

    task automatic test_trap();
        int cyc; logic [31:0] v;
        do_reset(); prog.delete();
        prog.push_back(enc_i(L_ADDI, 5'd1, 5'd0, 16'd1));
        prog.push_back(32'hB800_0000);
        prog.push_back(enc_i(L_ADDI, 5'd2, 5'd0, 16'd2));
        prog.push_back(HALTW);
        load_prog(); run_prog(cyc); rdreg(5'd2, v);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL trap_halted: got %b want 1", halted); end
`ifdef MIPS32_MC_TRAP_EN
        total++; if (trap !== 1'b1)     begin bad++; $display("FAIL trap_flag: got %b want 1", trap); end
        total++; if (pc !== 6'd1)       begin bad++; $display("FAIL trap_pc: got %0d want 1", pc); end
        total++; if (instret !== 32'd1) begin bad++; $display("FAIL trap_instret: got %0d want 1", instret); end
        total++; if (v !== 32'd0)       begin bad++; $display("FAIL trap_r2: got %0d want 0", v); end
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        total++; if (trap !== 1'b0)     begin bad++; $display("FAIL trap_clear: got %b want 0", trap); end
        cyc = 0;
        while (!halted && cyc < 200) begin @(posedge clk); #1; cyc++; end
`else
        total++; if (trap !== 1'b0)     begin bad++; $display("FAIL trap_flag: got %b want 0", trap); end
        total++; if (pc !== 6'd3)       begin bad++; $display("FAIL trap_pc: got %0d want 3", pc); end
        total++; if (instret !== 32'd3) begin bad++; $display("FAIL trap_instret: got %0d want 3", instret); end
        total++; if (v !== 32'd2)       begin bad++; $display("FAIL trap_r2: got %0d want 2", v); end
`endif
    endtask

    task automatic test_random();
        int cyc, n, idx;
        logic [31:0] ins, v, ea;
        logic [4:0] rd, rs1, rs2, sh;
        logic [15:0] imm;
        for (int t = 0; t < 16; t++) begin
            do_reset(); prog.delete();
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_cyc = 0; m_ret = 0;
            n = $urandom_range(8, 20);
            for (int k = 0; k < n; k++) begin
                rd  = 5'($urandom_range(0, 7));
                rs1 = 5'($urandom_range(0, 7));
                rs2 = 5'($urandom_range(0, 7));
                sh  = 5'($urandom_range(0, 3));
                imm = 16'($urandom);
                case ($urandom_range(0, 9))
                    0, 1:       ins = enc_i(L_ADDI, rd, 5'd0, imm);
                    2, 3, 4, 5: ins = enc_r({2'b00, 4'($urandom_range(0, 5))}, rd, rs1, rs2, sh);
                    6:          ins = enc_i({2'b01, 4'($urandom_range(0, 5))}, rd, rs1, imm);
                    7:          ins = enc_i(L_ST, rd, rs1, {12'd0, imm[3:0]});
                    8: begin
                        ea  = m_regs[rs1] + {28'd0, imm[3:0]};
                        idx = int'(ea % 32'(DMEM_DEPTH));
                        ins = enc_i(m_dval[idx] ? L_LD : L_ST, rd, rs1, {12'd0, imm[3:0]});
                    end
                    default:    ins = enc_i(imm[0] ? L_BNEZ : L_BEQZ, 5'd0, rs1, 16'd0);
                endcase
                prog.push_back(ins);
                m_exec(ins);
            end
            prog.push_back(HALTW);
            m_cyc += 2;
            load_prog(); run_prog(cyc);
            total++; if (halted !== 1'b1) begin bad++; $display("FAIL rnd%0d_halted: got %b want 1", t, halted); end
            total++; if (pc !== 6'(n))    begin bad++; $display("FAIL rnd%0d_pc: got %0d want %0d", t, pc, n); end
            total++; if (instret !== 32'(m_ret)) begin bad++; $display("FAIL rnd%0d_instret: got %0d want %0d", t, instret, m_ret); end
            total++; if (cyc !== m_cyc)   begin bad++; $display("FAIL rnd%0d_cycles: got %0d want %0d", t, cyc, m_cyc); end
            for (int r = 0; r < 32; r++) begin
                rdreg(5'(r), v);
                total++; if (v !== m_regs[r]) begin bad++; $display("FAIL rnd%0d_r%0d: got %0h want %0h", t, r, v, m_regs[r]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DMEM_DEPTH; i++) begin m_dval[i] = 1'b0; m_dmem[i] = '0; end
        test_reset();
        test_arith();
        test_ldst();
        test_countdown();
        test_r0_and_guard();
        test_branch_wrap();
        test_reset_mid_store();
        test_trap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
